// File: rtl/execute_pkg.sv
// Shared definitions for the multi-cycle execute stage: opcodes, ALU controls,
// FSM states and branch-condition decode.
package execute_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd1;
   localparam logic [5:0] OP_JAL   = 6'd2;
   localparam logic [5:0] OP_ADDI  = 6'd3;
   localparam logic [5:0] OP_SUBI  = 6'd4;
   localparam logic [5:0] OP_ANDI  = 6'd5;
   localparam logic [5:0] OP_ORI   = 6'd6;
   localparam logic [5:0] OP_SLTI  = 6'd7;
   localparam logic [5:0] OP_LW    = 6'd8;
   localparam logic [5:0] OP_SW    = 6'd9;
   localparam logic [5:0] OP_BEQ   = 6'd10;
   localparam logic [5:0] OP_BNE   = 6'd11;
   localparam logic [5:0] OP_BGT   = 6'd12;
   localparam logic [5:0] OP_BGTE  = 6'd13;
   localparam logic [5:0] OP_BLE   = 6'd14;
   localparam logic [5:0] OP_BLEQ  = 6'd15;

   // R-type funct 0..8 map one-to-one onto the ALU control codes
   localparam logic [5:0] FN_ALU_MAX = 6'd8;
   localparam logic [5:0] FN_JR      = 6'd9;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_ADDU = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_SUBU = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SLT  = 4'd8
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MEM,
      ST_DONE
   } state_t;

   // eq/lt are rs_val compared against rt_val (signed); non-branch ops never take
   function automatic logic branch_taken(input logic [5:0] op, input logic eq, input logic lt);
      logic taken;
      taken = 1'b0;
      case (op)
         OP_BEQ:  taken = eq;
         OP_BNE:  taken = !eq;
         OP_BGT:  taken = !lt && !eq;
         OP_BGTE: taken = !lt;
         OP_BLE:  taken = lt;
         OP_BLEQ: taken = lt || eq;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational XLEN-wide ALU with a signed-overflow flag for add/sub.
module alu_param
   import execute_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      shamt,
   input  logic [3:0]      ctrl,
   output logic [XLEN-1:0] result,
   output logic            ovf
);

   alu_ctrl_t       op_sel;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;

   assign op_sel = alu_ctrl_t'(ctrl);
   assign sum    = a + b;
   assign diff   = a - b;

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (op_sel)
         ALU_ADD: begin
            result = sum;
            ovf    = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
         end
         ALU_ADDU: result = sum;
         ALU_SUB: begin
            result = diff;
            ovf    = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
         end
         ALU_SUBU: result = diff;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_SLL:  result = a << shamt;
         ALU_SRL:  result = a >> shamt;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/execute_unit_fsm.sv
// Multi-cycle execute stage: accepts one decoded instruction, runs ALU/branch/jump
// or a bounded data-memory access, and reports results with a one-cycle done pulse.
module execute_unit_fsm
   import execute_pkg::*;
#(
   parameter  int XLEN        = 32,
   parameter  int NREG        = 32,
   parameter  int RA_REG      = 31,
   parameter  int MEM_TIMEOUT = 16,
   localparam int RW          = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      op,
   input  logic [5:0]      funct,
   input  logic [RW-1:0]   rs,
   input  logic [RW-1:0]   rt,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   input  logic [XLEN-1:0] rd_val,
   input  logic [XLEN-1:0] imm,
   input  logic [4:0]      shamt,
   input  logic [XLEN-1:0] pc,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            done,
   output logic            wb_en,
   output logic [RW-1:0]   wb_addr,
   output logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] next_pc,
   output logic            exc_ovf,
   output logic            exc_bus
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   state_t state_reg, state_next;

   logic [5:0]      op_reg, funct_reg;
   logic [RW-1:0]   rs_reg;
   logic [XLEN-1:0] rs_val_reg, rt_val_reg, rd_val_reg, imm_reg, pc_reg;
   logic [4:0]      shamt_reg;

   logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
   logic            mem_we_reg, mem_we_next;
   logic [XLEN-1:0] mem_addr_reg, mem_addr_next, mem_wdata_reg, mem_wdata_next;
   logic            wb_en_reg, wb_en_next;
   logic [RW-1:0]   wb_addr_reg, wb_addr_next;
   logic [XLEN-1:0] wb_data_reg, wb_data_next, next_pc_reg, next_pc_next;
   logic            exc_ovf_reg, exc_ovf_next, exc_bus_reg, exc_bus_next;

   alu_ctrl_t       alu_ctrl;
   logic            is_alu, use_imm, is_mem;
   logic [XLEN-1:0] alu_b, alu_result, pc_plus1;
   logic            alu_ovf, cmp_eq, cmp_lt;

   // The rt index is carried by the decode format but never needed here
   logic unused_rt;
   assign unused_rt = ^rt;

   assign in_ready  = (state_reg == ST_IDLE);
   assign mem_req   = (state_reg == ST_MEM);
   assign done      = (state_reg == ST_DONE);
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign wb_en     = wb_en_reg;
   assign wb_addr   = wb_addr_reg;
   assign wb_data   = wb_data_reg;
   assign next_pc   = next_pc_reg;
   assign exc_ovf   = exc_ovf_reg;
   assign exc_bus   = exc_bus_reg;

   assign pc_plus1 = pc_reg + XLEN'(1);
   assign cmp_eq   = (rs_val_reg == rt_val_reg);
   assign cmp_lt   = ($signed(rs_val_reg) < $signed(rt_val_reg));
   assign is_mem   = (op_reg == OP_LW) || (op_reg == OP_SW);
   assign alu_b    = use_imm ? imm_reg : rd_val_reg;
   assign cnt_inc  = cnt_reg + CW'(1);

   always_comb begin
      alu_ctrl = ALU_ADD;
      is_alu   = 1'b0;
      use_imm  = 1'b0;
      case (op_reg)
         OP_RTYPE: if (funct_reg <= FN_ALU_MAX) begin
            is_alu   = 1'b1;
            alu_ctrl = alu_ctrl_t'(funct_reg[3:0]);
         end
         OP_ADDI: begin is_alu = 1'b1; use_imm = 1'b1; alu_ctrl = ALU_ADD; end
         OP_SUBI: begin is_alu = 1'b1; use_imm = 1'b1; alu_ctrl = ALU_SUB; end
         OP_ANDI: begin is_alu = 1'b1; use_imm = 1'b1; alu_ctrl = ALU_AND; end
         OP_ORI:  begin is_alu = 1'b1; use_imm = 1'b1; alu_ctrl = ALU_OR;  end
         OP_SLTI: begin is_alu = 1'b1; use_imm = 1'b1; alu_ctrl = ALU_SLT; end
         default: is_alu = 1'b0;
      endcase
   end

   alu_param #(.XLEN(XLEN)) u_alu (
      .a      (rt_val_reg),
      .b      (alu_b),
      .shamt  (shamt_reg),
      .ctrl   (alu_ctrl),
      .result (alu_result),
      .ovf    (alu_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Result outputs only change on the transition into DONE so they hold between pulses
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      wb_en_next     = wb_en_reg;
      wb_addr_next   = wb_addr_reg;
      wb_data_next   = wb_data_reg;
      next_pc_next   = next_pc_reg;
      exc_ovf_next   = exc_ovf_reg;
      exc_bus_next   = exc_bus_reg;
      case (state_reg)
         ST_IDLE: if (in_valid) state_next = ST_EXEC;
         ST_EXEC: begin
            if (is_mem) begin
               state_next     = ST_MEM;
               cnt_next       = '0;
               mem_addr_next  = rt_val_reg + imm_reg;
               mem_we_next    = (op_reg == OP_SW);
               mem_wdata_next = rs_val_reg;
            end else begin
               state_next   = ST_DONE;
               wb_en_next   = 1'b0;
               wb_addr_next = rs_reg;
               wb_data_next = '0;
               next_pc_next = pc_plus1;
               exc_ovf_next = 1'b0;
               exc_bus_next = 1'b0;
               if (is_alu) begin
                  wb_en_next   = !alu_ovf;
                  wb_data_next = alu_result;
                  exc_ovf_next = alu_ovf;
               end else begin
                  case (op_reg)
                     OP_J: next_pc_next = imm_reg;
                     OP_JAL: begin
                        next_pc_next = imm_reg;
                        wb_en_next   = 1'b1;
                        wb_addr_next = RW'(RA_REG);
                        wb_data_next = pc_plus1;
                     end
                     OP_RTYPE: if (funct_reg == FN_JR) next_pc_next = rs_val_reg;
                     default: if (branch_taken(op_reg, cmp_eq, cmp_lt))
                        next_pc_next = pc_plus1 + imm_reg;
                  endcase
               end
            end
         end
         ST_MEM: begin
            cnt_next = cnt_inc;
            // A late ack in the final timeout cycle still wins over the bus error
            if (mem_ack || (cnt_inc == CW'(MEM_TIMEOUT))) begin
               state_next   = ST_DONE;
               cnt_next     = '0;
               wb_addr_next = rs_reg;
               next_pc_next = pc_plus1;
               exc_ovf_next = 1'b0;
               exc_bus_next = !mem_ack;
               wb_en_next   = mem_ack && !mem_we_reg;
               wb_data_next = (mem_ack && !mem_we_reg) ? mem_rdata : '0;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg       <= '0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         wb_en_reg     <= 1'b0;
         wb_addr_reg   <= '0;
         wb_data_reg   <= '0;
         next_pc_reg   <= '0;
         exc_ovf_reg   <= 1'b0;
         exc_bus_reg   <= 1'b0;
      end else begin
         cnt_reg       <= cnt_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         wb_en_reg     <= wb_en_next;
         wb_addr_reg   <= wb_addr_next;
         wb_data_reg   <= wb_data_next;
         next_pc_reg   <= next_pc_next;
         exc_ovf_reg   <= exc_ovf_next;
         exc_bus_reg   <= exc_bus_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg     <= '0;
         funct_reg  <= '0;
         rs_reg     <= '0;
         rs_val_reg <= '0;
         rt_val_reg <= '0;
         rd_val_reg <= '0;
         imm_reg    <= '0;
         shamt_reg  <= '0;
         pc_reg     <= '0;
      end else if (state_reg == ST_IDLE && in_valid) begin
         op_reg     <= op;
         funct_reg  <= funct;
         rs_reg     <= rs;
         rs_val_reg <= rs_val;
         rt_val_reg <= rt_val;
         rd_val_reg <= rd_val;
         imm_reg    <= imm;
         shamt_reg  <= shamt;
         pc_reg     <= pc;
      end
   end

endmodule

// File: tb/tb_execute_unit_fsm.sv
// Bench for execute_unit_fsm: directed vector table, reset-abort sequence and
// randomized instructions checked against an arithmetic reference model.
module tb_execute_unit_fsm;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, shamt;
   logic [31:0] rs_val, rt_val, rd_val, imm, pc;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        done, wb_en, exc_ovf, exc_bus;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, next_pc;

   always #5 clk = ~clk;

   execute_unit_fsm #(.XLEN(32), .NREG(32), .RA_REG(31), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .funct(funct), .rs(rs), .rt(rt), .rs_val(rs_val), .rt_val(rt_val),
      .rd_val(rd_val), .imm(imm), .shamt(shamt), .pc(pc),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done), .wb_en(wb_en),
      .wb_addr(wb_addr), .wb_data(wb_data), .next_pc(next_pc),
      .exc_ovf(exc_ovf), .exc_bus(exc_bus)
   );

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic [4:0]  rs;
      logic [31:0] rs_val, rt_val, rd_val, imm;
      logic [4:0]  shamt;
      logic [31:0] pc;
      int          ack_delay;   // ack on this mem_req cycle; 0 = never
      logic [31:0] rdata;
   } txn_t;

   typedef struct {
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data, next_pc;
      logic        ovf, bus;
      int          lat;
      logic        is_mem;
      logic [31:0] mem_addr;
      logic        mem_we;
      logic [31:0] mem_wdata;
   } exp_t;

   typedef struct {
      txn_t t;
      exp_t e;
   } vec_t;

   int total = 0;
   int bad = 0;

   // memory responder state
   int          cur_ack_delay = 0;
   logic [31:0] cur_rdata = '0;
   int          req_cnt = 0;
   int          req_total = 0;
   logic [31:0] cap_addr, cap_wdata;
   logic        cap_we;
   logic        unstable = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic txn_t tx(input int o, input int f, input int r, input logic [31:0] sv,
                               input logic [31:0] tv, input logic [31:0] dv, input logic [31:0] im,
                               input int sh, input logic [31:0] p, input int d, input logic [31:0] rd);
      txn_t t;
      t.op = 6'(o); t.funct = 6'(f); t.rs = 5'(r); t.rs_val = sv; t.rt_val = tv; t.rd_val = dv;
      t.imm = im; t.shamt = 5'(sh); t.pc = p; t.ack_delay = d; t.rdata = rd;
      return t;
   endfunction

   function automatic exp_t ex(input logic we, input int wa, input logic [31:0] wd, input logic [31:0] np,
                               input logic ov, input logic bu, input int lat, input logic im,
                               input logic [31:0] ma, input logic mw, input logic [31:0] md);
      exp_t e;
      e.wb_en = we; e.wb_addr = 5'(wa); e.wb_data = wd; e.next_pc = np; e.ovf = ov; e.bus = bu;
      e.lat = lat; e.is_mem = im; e.mem_addr = ma; e.mem_we = mw; e.mem_wdata = md;
      return e;
   endfunction

   // Reference model: instruction semantics via plain integer arithmetic
   function automatic exp_t model(input txn_t t);
      exp_t        e;
      int          code;
      longint      sa, sb, full;
      logic [31:0] b, r;
      int          si, ti, n;
      bit          tmo, taken;
      e = ex(0, t.rs, 0, t.pc + 1, 0, 0, 2, 0, 0, 0, 0);
      code = -1;
      if (t.op == 0 && t.funct <= 8) code = int'(t.funct);
      else if (t.op == 3) code = 0;
      else if (t.op == 4) code = 2;
      else if (t.op == 5) code = 4;
      else if (t.op == 6) code = 5;
      else if (t.op == 7) code = 8;
      b = (t.op == 0) ? t.rd_val : t.imm;
      sa = longint'($signed(t.rt_val));
      sb = longint'($signed(b));
      if (code >= 0) begin
         full = 0;
         r = 0;
         case (code)
            0, 1: begin full = sa + sb; r = 32'(full); end
            2, 3: begin full = sa - sb; r = 32'(full); end
            4: r = t.rt_val & b;
            5: r = t.rt_val | b;
            6: r = t.rt_val << t.shamt;
            7: r = t.rt_val >> t.shamt;
            default: r = (sa < sb) ? 32'd1 : 32'd0;
         endcase
         e.ovf = (code == 0 || code == 2) && (full > 64'sd2147483647 || full < -64'sd2147483648);
         e.wb_en = !e.ovf;
         e.wb_data = r;
      end else if (t.op == 1) begin
         e.next_pc = t.imm;
      end else if (t.op == 2) begin
         e.next_pc = t.imm; e.wb_en = 1; e.wb_addr = 5'd31; e.wb_data = t.pc + 1;
      end else if (t.op == 0 && t.funct == 9) begin
         e.next_pc = t.rs_val;
      end else if (t.op == 8 || t.op == 9) begin
         tmo = (t.ack_delay == 0 || t.ack_delay > TMO);
         n = tmo ? TMO : t.ack_delay;
         e.lat = 2 + n; e.is_mem = 1; e.bus = tmo;
         e.mem_addr = t.rt_val + t.imm; e.mem_we = (t.op == 9); e.mem_wdata = t.rs_val;
         if (t.op == 8 && !tmo) begin e.wb_en = 1; e.wb_data = t.rdata; end
      end else if (t.op >= 10 && t.op <= 15) begin
         si = $signed(t.rs_val);
         ti = $signed(t.rt_val);
         case (t.op)
            10: taken = (si == ti);
            11: taken = (si != ti);
            12: taken = (si > ti);
            13: taken = (si >= ti);
            14: taken = (si < ti);
            default: taken = (si <= ti);
         endcase
         if (taken) e.next_pc = t.pc + 1 + t.imm;
      end
      return e;
   endfunction

   task automatic scramble();
      op = 6'($urandom); funct = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
      rs_val = $urandom; rt_val = $urandom; rd_val = $urandom; imm = $urandom;
      shamt = 5'($urandom); pc = $urandom;
   endtask

   task automatic drive(input txn_t t);
      op = t.op; funct = t.funct; rs = t.rs; rt = 5'($urandom); rs_val = t.rs_val;
      rt_val = t.rt_val; rd_val = t.rd_val; imm = t.imm; shamt = t.shamt; pc = t.pc;
   endtask

   // Memory responder: acks on the requested mem_req cycle, watches for unstable requests
   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            req_cnt++;
            req_total++;
            if (req_cnt == 1) begin
               cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
            end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
               unstable = 1'b1;
            end
            mem_ack = (cur_ack_delay != 0 && req_cnt == cur_ack_delay);
            mem_rdata = mem_ack ? cur_rdata : $urandom;
         end else begin
            req_cnt = 0;
            mem_ack = 1'b0;
         end
      end
   end

   task automatic run_one(input int idx, input txn_t t, input exp_t e);
      int lat;
      bit seen;
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      cur_ack_delay = t.ack_delay;
      cur_rdata = t.rdata;
      req_total = 0;
      unstable = 1'b0;
      drive(t);
      in_valid = 1'b1;
      @(posedge clk);
      lat = 0;
      seen = 0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            lat = c;
            in_valid = 1'b0;
         end else begin
            chk("in_ready_busy", in_ready, 0);
            scramble();   // in_valid stays high: busy-time requests must be ignored
         end
      end
      in_valid = 1'b0;
      chk("done_seen", seen, 1);
      chk("latency", lat, e.lat);
      chk("wb_en", wb_en, e.wb_en);
      if (e.wb_en) begin
         chk("wb_addr", wb_addr, e.wb_addr);
         chk("wb_data", wb_data, e.wb_data);
      end
      chk("next_pc", next_pc, e.next_pc);
      chk("exc_ovf", exc_ovf, e.ovf);
      chk("exc_bus", exc_bus, e.bus);
      chk("req_cycles", req_total, e.is_mem ? e.lat - 2 : 0);
      if (e.is_mem) begin
         chk("mem_addr", cap_addr, e.mem_addr);
         chk("mem_we", cap_we, e.mem_we);
         if (e.mem_we) chk("mem_wdata", cap_wdata, e.mem_wdata);
         chk("mem_stable", unstable, 0);
      end
      $display("txn %0d op=%0d funct=%0d lat=%0d wb_en=%0b wb_data=0x%08h next_pc=0x%08h ovf=%0b bus=%0b",
               idx, t.op, t.funct, lat, wb_en, wb_data, next_pc, exc_ovf, exc_bus);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("next_pc_hold", next_pc, e.next_pc);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         5: return 32'($urandom_range(0, 64));
         default: return $urandom;
      endcase
   endfunction

   vec_t vq[$];

   task automatic add_vec(input txn_t t, input exp_t e);
      vec_t v;
      v.t = t;
      v.e = e;
      vq.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      txn_t t;
      exp_t e;
      in_valid = 1'b0;
      op = '0; funct = '0; rs = '0; rt = '0; shamt = '0;
      rs_val = '0; rt_val = '0; rd_val = '0; imm = '0; pc = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_next_pc", next_pc, 0);
      chk("rst_exc_bus", exc_bus, 0);
      chk("rst_mem_addr", mem_addr, 0);
      rst_n = 1'b1;

      add_vec(tx(0, 0, 4, 0, 5, 7, 0, 0, 10, 0, 0), ex(1, 4, 12, 11, 0, 0, 2, 0, 0, 0, 0));
      add_vec(tx(3, 0, 2, 0, 32'h7FFFFFFF, 0, 1, 0, 100, 0, 0), ex(0, 2, 0, 101, 1, 0, 2, 0, 0, 0, 0));
      add_vec(tx(8, 0, 5, 32'h11, 32'h100, 0, 4, 0, 30, 3, 32'hDEADBEEF),
              ex(1, 5, 32'hDEADBEEF, 31, 0, 0, 5, 1, 32'h104, 0, 0));
      add_vec(tx(9, 0, 6, 32'hCAFE, 32'h200, 0, 8, 0, 40, 0, 0),
              ex(0, 6, 0, 41, 0, 1, 18, 1, 32'h208, 1, 32'hCAFE));
      add_vec(tx(12, 0, 0, 32'hFFFFFFFF, 1, 0, 8, 0, 20, 0, 0), ex(0, 0, 0, 21, 0, 0, 2, 0, 0, 0, 0));
      add_vec(tx(2, 0, 0, 0, 0, 0, 32'h40, 0, 20, 0, 0), ex(1, 31, 21, 32'h40, 0, 0, 2, 0, 0, 0, 0));
      add_vec(tx(10, 0, 0, 7, 7, 0, 32'hFFFFFFFD, 0, 50, 0, 0), ex(0, 0, 0, 48, 0, 0, 2, 0, 0, 0, 0));
      add_vec(tx(0, 2, 3, 0, 32'h80000000, 1, 0, 0, 60, 0, 0), ex(0, 3, 0, 61, 1, 0, 2, 0, 0, 0, 0));
      add_vec(tx(0, 6, 7, 0, 1, 0, 0, 31, 70, 0, 0), ex(1, 7, 32'h80000000, 71, 0, 0, 2, 0, 0, 0, 0));
      add_vec(tx(0, 8, 8, 0, 32'hFFFFFFFF, 1, 0, 0, 80, 0, 0), ex(1, 8, 1, 81, 0, 0, 2, 0, 0, 0, 0));
      add_vec(tx(0, 9, 0, 32'h1234, 0, 0, 0, 0, 90, 0, 0), ex(0, 0, 0, 32'h1234, 0, 0, 2, 0, 0, 0, 0));
      add_vec(tx(20, 0, 1, 0, 0, 0, 0, 0, 95, 0, 0), ex(0, 1, 0, 96, 0, 0, 2, 0, 0, 0, 0));
      add_vec(tx(8, 0, 9, 0, 32'h300, 0, 0, 0, 110, 16, 32'h55AA55AA),
              ex(1, 9, 32'h55AA55AA, 111, 0, 0, 18, 1, 32'h300, 0, 0));
      add_vec(tx(8, 0, 10, 0, 32'h10, 0, 32'hFFFFFFF0, 0, 120, 1, 32'h12345678),
              ex(1, 10, 32'h12345678, 121, 0, 0, 3, 1, 0, 0, 0));
      add_vec(tx(14, 0, 0, 32'h80000000, 0, 0, 5, 0, 130, 0, 0), ex(0, 0, 0, 136, 0, 0, 2, 0, 0, 0, 0));
      add_vec(tx(0, 7, 11, 0, 32'h80000000, 0, 0, 4, 140, 0, 0), ex(1, 11, 32'h08000000, 141, 0, 0, 2, 0, 0, 0, 0));
      for (int i = 0; i < vq.size(); i++) run_one(i, vq[i].t, vq[i].e);

      // reset asserted while the load waits in MEM: request drops at once, no done
      @(negedge clk);
      cur_ack_delay = 0;
      drive(tx(8, 0, 3, 0, 32'h400, 0, 0, 0, 200, 0, 0));
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mreset_req_before", mem_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mreset_req_async", mem_req, 0);
      chk("mreset_done", done, 0);
      chk("mreset_in_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mreset_no_done", done, 0);
      end
      rst_n = 1'b1;
      chk("mreset_next_pc", next_pc, 0);
      chk("mreset_mem_addr", mem_addr, 0);
      @(negedge clk);
      chk("mreset_no_done_after", done, 0);
      t = tx(0, 0, 4, 0, 5, 7, 0, 0, 10, 0, 0);
      run_one(100, t, model(t));

      for (int i = 0; i < 60; i++) begin
         t.op = 6'($urandom_range(0, 17));
         t.funct = 6'($urandom_range(0, 11));
         t.rs = 5'($urandom);
         t.rs_val = pick();
         t.rt_val = ($urandom_range(0, 3) == 0) ? t.rs_val : pick();
         t.rd_val = pick();
         t.imm = pick();
         t.shamt = 5'($urandom);
         t.pc = $urandom;
         t.ack_delay = $urandom_range(0, 18);
         t.rdata = $urandom;
         e = model(t);
         run_one(200 + i, t, e);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
